alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: in_valid  input  1  request present on Operation/SrcA/SrcB.
REQ-005 Port: in_ready  output  1  block accepts request this cycle.
REQ-006 Port: Operation  input  4  operation code from the ALU controller.
REQ-007 Port: SrcA  input  32  first operand.
REQ-008 Port: SrcB  input  32  second operand; bits [4:0] are the shift amount for shifts.
REQ-009 Port: out_valid  output  1  result present on ALUResult/Zero.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: ALUResult  output  32  registered result.
REQ-012 Port: Zero  output  1  registered (ALUResult == 0).

Function
REQ-013 Decoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 BEQ, 1001 BNE, 1010 BGE(signed), 1100 SLT/BLT(signed); all other codes yield ALUResult 0.
REQ-014 Compare/branch ops SHALL return {31'b0, cond}; cond is A==B, A!=B, signed A>=B, signed A<B respectively.
REQ-015 ADD/SUB SHALL wrap modulo 2^32; no overflow flag.
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE; transfer occurs on in_valid&&in_ready, delivery on out_valid&&out_ready.
REQ-017 in_ready SHALL be 1 in IDLE, out_ready in DONE, 0 in SHIFT.
REQ-018 Non-shift op accepted: result computed and registered, next state DONE; out_valid rises the cycle after accept (latency 1).
REQ-019 Shift op accepted with shamt 0: result = SrcA, next state DONE, latency 1.
REQ-020 Shift op accepted with shamt N>0: operand and counter=N registered, state SHIFT; one bit shifted per cycle (SRA replicates bit 31); DONE entered after the Nth shift; latency N+1.
REQ-021 In DONE, out_valid=1 and ALUResult/Zero SHALL hold stable until delivery.
REQ-022 DONE with out_ready=1 and in_valid=1: result delivered and new request accepted same cycle (back-to-back, no bubble); with in_valid=0 return to IDLE.
REQ-023 Inputs SHALL be ignored except in the accept cycle; out_valid=0 in IDLE and SHIFT.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, out_valid 0, ALUResult 0, Zero 1, counter 0, in_ready 1 after release; any in-flight operation is discarded, no output produced.

Configuration
REQ-025 With ALU_FAST_SHIFT_EN defined, shifts SHALL use a single-cycle barrel shifter: latency 1 for all ops, SHIFT state and counter not built.
REQ-026 Without ALU_FAST_SHIFT_EN, shifts SHALL be iterative per REQ-020.

Structure
REQ-027 Package alu_pkg SHALL hold the 4-bit operation enum (values per REQ-013), the FSM state enum and DATA_WIDTH/SHAMT_WIDTH constants; shared with the ALU controller.
REQ-028 Sub-module alu_shift_unit SHALL contain the shift datapath (iterative step or barrel per REQ-025/026); everything else resides in alu_iter.

Verification
REQ-029 ADD 5+7 -> out_valid 1 cycle after accept, ALUResult 12, Zero 0.
REQ-030 SUB 7-7 -> ALUResult 0, Zero 1; BLT A=0xFFFFFFFF B=1 -> ALUResult 1.
REQ-031 SRA A=0x80000000 shamt 4 -> ALUResult 0xF8000000, latency 5 (1 with ALU_FAST_SHIFT_EN); SLL shamt 0 A=0x1234 -> 0x1234, latency 1.
REQ-032 out_ready held low 3 cycles in DONE -> ALUResult stable, in_ready 0; then out_ready=1 with in_valid=1 (OR 0xF0|0x0F) -> both handshakes same cycle, next out_valid 0x000000FF one cycle later.
REQ-033 rst_n pulsed low during SRL shamt 31 -> out_valid 0 and ALUResult 0 immediately, no result delivered, in_ready 1 after release.
REQ-034 Operation 1111 -> ALUResult 0, Zero 1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, sequencer states and datapath widths.
// Shared with the ALU controller, so keep the operation encodings fixed.
package alu_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_WIDTH = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_BNE = 4'b1001,
    OP_BGE = 4'b1010,
    OP_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Shift datapath. Default build: one-bit step per call (pass-through when shamt is 0).
// With ALU_FAST_SHIFT_EN defined: full barrel shift by shamt in one cycle.
module alu_shift_unit
  import alu_pkg::*;
(
  input  alu_op_e                op,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  result
);

`ifdef ALU_FAST_SHIFT_EN
  always_comb begin
    result = data;
    case (op)
      OP_SLL:  result = data << shamt;
      OP_SRL:  result = data >> shamt;
      OP_SRA:  result = DATA_WIDTH'($signed(data) >>> shamt);
      default: result = data;
    endcase
  end
`else
  logic [DATA_WIDTH-1:0] step;

  always_comb begin
    step = data;
    case (op)
      OP_SLL:  step = {data[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, data[DATA_WIDTH-1:1]};
      OP_SRA:  step = {data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
      default: step = data;
    endcase
  end

  // shamt of zero means "no shift left to do": the operand passes straight through
  assign result = (shamt == '0) ? data : step;
`endif

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU with iterative shifter; ALU_FAST_SHIFT_EN selects a single-cycle
// barrel shifter instead (no SHIFT state, no shift counter).
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready=1
// ST_SHIFT | shifting one bit per cycle until counter reaches terminal count
// ST_DONE  | result valid and held until out_ready
module alu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  alu_op_e                op;
  alu_state_e             state;
  logic                   accept;
  logic                   go_shift;
  alu_op_e                sh_op;
  logic [DATA_WIDTH-1:0]  sh_data;
  logic [SHAMT_WIDTH-1:0] sh_amt;
  logic [DATA_WIDTH-1:0]  sh_out;
  logic [DATA_WIDTH-1:0]  alu_res;

  assign op       = alu_op_e'(Operation);
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift = 1'b0;
  assign sh_op    = op;
  assign sh_data  = SrcA;
  assign sh_amt   = SrcB[SHAMT_WIDTH-1:0];
`else
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  shreg;
  alu_op_e                op_q;

  assign go_shift = (op inside {OP_SLL, OP_SRL, OP_SRA}) && (SrcB[SHAMT_WIDTH-1:0] != '0);
  // the shifter serves the accept cycle from the inputs and the SHIFT state from the working register
  assign sh_op    = (state == ST_SHIFT) ? op_q  : op;
  assign sh_data  = (state == ST_SHIFT) ? shreg : SrcA;
  assign sh_amt   = (state == ST_SHIFT) ? cnt   : SrcB[SHAMT_WIDTH-1:0];
`endif

  alu_shift_unit u_shift (
    .op     (sh_op),
    .data   (sh_data),
    .shamt  (sh_amt),
    .result (sh_out)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:                 alu_res = SrcA & SrcB;
      OP_OR:                  alu_res = SrcA | SrcB;
      OP_ADD:                 alu_res = SrcA + SrcB;
      OP_XOR:                 alu_res = SrcA ^ SrcB;
      OP_SUB:                 alu_res = SrcA - SrcB;
      OP_SLL, OP_SRL, OP_SRA: alu_res = sh_out;
      OP_BEQ:                 alu_res = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_BNE:                 alu_res = {{(DATA_WIDTH-1){1'b0}}, SrcA != SrcB};
      OP_BGE:                 alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) >= $signed(SrcB)};
      OP_SLT:                 alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) <  $signed(SrcB)};
      default:                alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      cnt       <= '0;
      shreg     <= '0;
      op_q      <= OP_AND;
`endif
    end else if (accept) begin
      if (!go_shift) begin
        state     <= ST_DONE;
        out_valid <= 1'b1;
        ALUResult <= alu_res;
        Zero      <= (alu_res == '0);
      end
`ifndef ALU_FAST_SHIFT_EN
      else begin
        state     <= ST_SHIFT;
        out_valid <= 1'b0;
        shreg     <= SrcA;
        cnt       <= SrcB[SHAMT_WIDTH-1:0];
        op_q      <= op;
      end
`endif
    end else begin
      case (state)
`ifndef ALU_FAST_SHIFT_EN
        ST_SHIFT: begin
          shreg <= sh_out;
          cnt   <= cnt - SHAMT_WIDTH'(1);
          if (cnt == SHAMT_WIDTH'(1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            ALUResult <= sh_out;
            Zero      <= (sh_out == '0);
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized bench for alu_iter against an arithmetic reference model.
module tb_alu_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int total = 0;
  int bad   = 0;

  alu_iter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0110: return a - b;
      4'b0111: return 32'($signed(a) >>> b[4:0]);
      4'b1000: return {31'b0, a == b};
      4'b1001: return {31'b0, a != b};
      4'b1010: return {31'b0, $signed(a) >= $signed(b)};
      4'b1100: return {31'b0, $signed(a) < $signed(b)};
      default: return 32'b0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1 + 0 * int'(op) + 0 * int'(b[0]);
`else
    if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    exp       = ref_alu(op, a, b);
    exp_lat   = ref_lat(op, b);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      chk({tag, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, ALUResult, exp);
    chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp == 32'd0});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          seen;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = 4'h0;
    SrcA      = 32'h0;
    SrcB      = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result",    ALUResult,          32'd0);
    chk("rst_zero",      {31'b0, Zero},      32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

    run_op(4'b0010, 32'd5, 32'd7, "add_5_7");
    chk("add_const", ALUResult, 32'd12);
    run_op(4'b0110, 32'd7, 32'd7, "sub_7_7");
    run_op(4'b1100, 32'hFFFF_FFFF, 32'd1, "blt_neg");
    chk("blt_const", ALUResult, 32'd1);
    run_op(4'b0111, 32'h8000_0000, 32'd4, "sra_4");
    chk("sra_const", ALUResult, 32'hF800_0000);
    run_op(4'b0100, 32'h0000_1234, 32'd0, "sll_0");
    run_op(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, "op_1111");
    run_op(4'b1010, 32'h8000_0000, 32'h8000_0000, "bge_eq");
    run_op(4'b0100, 32'h0000_0001, 32'd31, "sll_31");

    // stall in DONE, then deliver and accept in the same cycle
    Operation = 4'b0011;
    SrcA      = 32'hA5A5_A5A5;
    SrcB      = 32'h0F0F_0F0F;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    held = ref_alu(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid",    {31'b0, out_valid}, 32'd1);
      chk("stall_result",   ALUResult,          held);
      chk("stall_in_ready", {31'b0, in_ready},  32'd0);
      SrcA = $urandom;
      @(negedge clk);
    end
    Operation = 4'b0001;
    SrcA      = 32'h0000_00F0;
    SrcB      = 32'h0000_000F;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready",  {31'b0, in_ready},  32'd1);
    chk("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_old_result", ALUResult,         held);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_next_valid",  {31'b0, out_valid}, 32'd1);
    chk("b2b_next_result", ALUResult,          32'h0000_00FF);
    chk("b2b_next_zero",   {31'b0, Zero},      32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", {31'b0, out_valid}, 32'd0);

    // reset while a long shift is in flight
    Operation = 4'b0101;
    SrcA      = 32'h8000_0000;
    SrcB      = 32'd31;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result",    ALUResult,          32'd0);
    chk("midrst_zero",      {31'b0, Zero},      32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    chk("midrst_no_output", 32'(seen), 32'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 31));
        1:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0h", n, rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
